// File: rtl/crack_scheduler_if.sv
// crack_scheduler_if: host start/result and crack-core dispatch bundle.
// master = scheduler side, slave = host plus crack cores.
interface crack_scheduler_if #(
  parameter int NCORES = 2,
  parameter int KEY_W  = 24
);
  logic                    en;
  logic                    rdy;
  logic [KEY_W-1:0]        key;
  logic                    key_valid;
  logic [NCORES-1:0]       core_en;
  logic [NCORES*KEY_W-1:0] core_start_key;
  logic [NCORES*KEY_W-1:0] core_end_key;
  logic [NCORES-1:0]       core_abort;
  logic [NCORES-1:0]       core_rdy;
  logic [NCORES*KEY_W-1:0] core_key;
  logic [NCORES-1:0]       core_key_valid;

  modport master (
    input  en,
    output rdy, key, key_valid,
    output core_en, core_start_key,
    output core_end_key, core_abort,
    input  core_rdy, core_key,
    input  core_key_valid
  );

  modport slave (
    output en,
    input  rdy, key, key_valid,
    input  core_en, core_start_key,
    input  core_end_key, core_abort,
    output core_rdy, core_key,
    output core_key_valid
  );
endinterface

// File: rtl/crack_scheduler.sv
// crack_scheduler: splits the ARC4 key space into chunks for crack cores.
// Option CRACK_SCHED_ROUNDROBIN_EN: rotating dispatch pointer.
module crack_scheduler #(
  parameter int NCORES     = 2,
  parameter int KEY_W      = 24,
  parameter int CHUNK_LOG2 = 16
) (
  input logic clk,
  input logic reset,
  crack_scheduler_if.master bus
);
  localparam int CW = KEY_W - CHUNK_LOG2;
  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic [1:0] {
    IDLE, RUN, ABORT, DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]     chunk;
  logic              exhausted;
  logic [NCORES-1:0] busy;
  logic [NCORES-1:0] guard;
  logic [NCORES-1:0] cmp;
  logic [NCORES-1:0] hit;
  logic [NCORES-1:0] disp_mask;
  logic              any_hit;
  logic              disp;
  logic [IW-1:0]     disp_idx;
  logic [KEY_W-1:0]  hit_key;
  logic              all_rdy;
  logic              abort_done;

`ifdef CRACK_SCHED_ROUNDROBIN_EN
  logic [IW-1:0] ptr;
  logic [IW-1:0] rr_j;
`endif

  // guard masks the stale core_rdy seen while core_en is in flight
  assign cmp        = busy & bus.core_rdy & ~guard;
  assign hit        = cmp & bus.core_key_valid;
  assign any_hit    = (state == RUN) && (|hit);
  assign all_rdy    = &bus.core_rdy;
  assign abort_done = all_rdy && (bus.core_abort == '0);
  assign disp_mask  = disp ? (NCORES'(1) << disp_idx) : '0;

  // lowest-index valid completion wins
  always_comb begin
    hit_key = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (hit[i]) hit_key = bus.core_key[i*KEY_W +: KEY_W];
    end
  end

  // pick at most one idle core to receive the next chunk
  always_comb begin
    disp     = 1'b0;
    disp_idx = '0;
`ifdef CRACK_SCHED_ROUNDROBIN_EN
    rr_j     = '0;
    for (int k = 0; k < NCORES; k++) begin
      rr_j = IW'((int'(ptr) + k) % NCORES);
      if (!disp && !busy[rr_j]) begin
        disp     = 1'b1;
        disp_idx = rr_j;
      end
    end
`else
    for (int i = 0; i < NCORES; i++) begin
      if (!disp && !busy[i]) begin
        disp     = 1'b1;
        disp_idx = IW'(i);
      end
    end
`endif
    if (state != RUN || exhausted || any_hit)
      disp = 1'b0;
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (bus.en) state_nxt = RUN;
      end
      RUN: begin
        if (any_hit)
          state_nxt = ABORT;
        else if (exhausted && busy == '0)
          state_nxt = DONE;
      end
      ABORT: begin
        if (abort_done) state_nxt = DONE;
      end
    endcase
  end

  // idle/result-available flag
  always_comb begin
    bus.rdy = (state == IDLE) || (state == DONE);
  end

  // chunk dispatch, completion tracking and result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chunk              <= '0;
      exhausted          <= 1'b0;
      busy               <= '0;
      guard              <= '0;
      bus.key            <= '0;
      bus.key_valid      <= 1'b0;
      bus.core_en        <= '0;
      bus.core_abort     <= '0;
      bus.core_start_key <= '0;
      bus.core_end_key   <= '0;
`ifdef CRACK_SCHED_ROUNDROBIN_EN
      ptr                <= '0;
`endif
    end else begin
      bus.core_en    <= '0;
      bus.core_abort <= '0;
      guard          <= '0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.en) begin
            chunk         <= '0;
            exhausted     <= 1'b0;
            bus.key       <= '0;
            bus.key_valid <= 1'b0;
          end
        end
        RUN: begin
          if (any_hit) begin
            bus.key        <= hit_key;
            bus.key_valid  <= 1'b1;
            busy           <= busy & ~cmp;
            bus.core_abort <= busy & ~cmp;
          end else begin
            busy        <= (busy & ~cmp) | disp_mask;
            guard       <= disp_mask;
            bus.core_en <= disp_mask;
            for (int i = 0; i < NCORES; i++) begin
              if (disp_mask[i]) begin
                bus.core_start_key[i*KEY_W +: KEY_W] <=
                  {chunk, {CHUNK_LOG2{1'b0}}};
                bus.core_end_key[i*KEY_W +: KEY_W] <=
                  {chunk, {CHUNK_LOG2{1'b1}}};
              end
            end
            if (disp) begin
              chunk <= chunk + 1'b1;
              if (chunk == '1) exhausted <= 1'b1;
`ifdef CRACK_SCHED_ROUNDROBIN_EN
              ptr <= (disp_idx == IW'(NCORES - 1)) ?
                     '0 : disp_idx + 1'b1;
`endif
            end
          end
        end
        ABORT: begin
          if (abort_done) busy <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_crack_scheduler.sv
// tb_crack_scheduler: directed checks of chunk dispatch, find/abort,
// tie-break, restart and async reset with behavioural crack cores.
module tb_crack_scheduler;
  localparam int NC = 2;
  localparam int KW = 24;
  localparam int CL = 22;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  crack_scheduler_if #(.NCORES(NC), .KEY_W(KW)) bif ();

  crack_scheduler #(
    .NCORES(NC), .KEY_W(KW), .CHUNK_LOG2(CL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  int lat [NC];
  logic find_en [NC];
  logic [KW-1:0] find_key [NC];

  logic [NC-1:0] m_rdy;
  logic [NC-1:0] m_kv;
  logic [NC*KW-1:0] m_key;
  int cnt [NC];
  logic [KW-1:0] m_lo [NC];
  logic [KW-1:0] m_hi [NC];

  int lg_core [$];
  int lg_lo [$];
  int lg_hi [$];
  int lg_cyc [$];
  int ab_cnt [NC];

  assign bif.core_rdy = m_rdy;
  assign bif.core_key_valid = m_kv;
  assign bif.core_key = m_key;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // behavioural crack core: busy for lat cycles, abortable
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rdy <= '1;
      m_kv  <= '0;
      m_key <= '0;
      for (int i = 0; i < NC; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (bif.core_abort[i]) begin
          m_rdy[i] <= 1'b1;
          cnt[i]   <= 0;
        end else if (bif.core_en[i]) begin
          m_rdy[i] <= 1'b0;
          m_kv[i]  <= 1'b0;
          cnt[i]   <= lat[i];
          m_lo[i]  <= bif.core_start_key[i*KW +: KW];
          m_hi[i]  <= bif.core_end_key[i*KW +: KW];
        end else if (cnt[i] > 0) begin
          if (cnt[i] == 1) begin
            m_rdy[i] <= 1'b1;
            if (find_en[i] && find_key[i] >= m_lo[i] &&
                find_key[i] <= m_hi[i]) begin
              m_kv[i] <= 1'b1;
              m_key[i*KW +: KW] <= find_key[i];
            end
          end
          cnt[i] <= cnt[i] - 1;
        end
      end
    end
  end

  // cycle stamp for dispatch log
  always @(posedge clk) cyc <= cyc + 1;

  // log dispatches and abort pulses
  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (bif.core_en[i]) begin
        lg_core.push_back(i);
        lg_lo.push_back(int'(bif.core_start_key[i*KW +: KW]));
        lg_hi.push_back(int'(bif.core_end_key[i*KW +: KW]));
        lg_cyc.push_back(cyc);
      end
      if (bif.core_abort[i]) ab_cnt[i]++;
    end
  end

  task automatic clear_logs();
    #1;
    lg_core.delete();
    lg_lo.delete();
    lg_hi.delete();
    lg_cyc.delete();
    for (int i = 0; i < NC; i++) ab_cnt[i] = 0;
  endtask

  task automatic start_run(input string tag);
    @(negedge clk);
    bif.en = 1'b1;
    @(negedge clk);
    bif.en = 1'b0;
    chk({tag, "_rdy_low"}, int'(bif.rdy), 0);
    chk({tag, "_kv_clr"}, int'(bif.key_valid), 0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!bif.rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, int'(bif.rdy), 1);
  endtask

  initial begin
    bif.en = 1'b0;
    for (int i = 0; i < NC; i++) begin
      lat[i] = 4;
      find_en[i] = 1'b0;
      find_key[i] = '0;
      ab_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    chk("rst_rdy", int'(bif.rdy), 1);
    chk("rst_kv", int'(bif.key_valid), 0);
    chk("rst_key", int'(bif.key), 0);
    chk("rst_core_en", int'(bif.core_en), 0);
    chk("rst_abort", int'(bif.core_abort), 0);
    chk("rst_skey", int'(bif.core_start_key), 0);
    chk("rst_ekey", int'(bif.core_end_key), 0);

    // full sweep, nothing found; stray en mid-run
    lat[0] = 5;
    lat[1] = 8;
    clear_logs();
    start_run("t1");
    repeat (4) @(negedge clk);
    bif.en = 1'b1;
    @(negedge clk);
    bif.en = 1'b0;
    wait_done("t1");
    chk("t1_ndisp", lg_core.size(), 4);
    chk("t1_c0", qget(lg_core, 0), 0);
    chk("t1_lo0", qget(lg_lo, 0), 'h000000);
    chk("t1_hi0", qget(lg_hi, 0), 'h3FFFFF);
    chk("t1_c1", qget(lg_core, 1), 1);
    chk("t1_lo1", qget(lg_lo, 1), 'h400000);
    chk("t1_hi1", qget(lg_hi, 1), 'h7FFFFF);
    chk("t1_consec", qget(lg_cyc, 1) - qget(lg_cyc, 0), 1);
    chk("t1_c2", qget(lg_core, 2), 0);
    chk("t1_lo2", qget(lg_lo, 2), 'h800000);
    chk("t1_c3", qget(lg_core, 3), 1);
    chk("t1_lo3", qget(lg_lo, 3), 'hC00000);
    chk("t1_hi3", qget(lg_hi, 3), 'hFFFFFF);
    chk("t1_kv", int'(bif.key_valid), 0);
    chk("t1_key", int'(bif.key), 0);
    chk("t1_abort", ab_cnt[0] + ab_cnt[1], 0);

    // core1 finds in chunk 1, core0 still busy -> aborted
    lat[0] = 10;
    lat[1] = 4;
    find_en[1] = 1'b1;
    find_key[1] = 24'h5A3C21;
    clear_logs();
    start_run("t2");
    wait_done("t2");
    chk("t2_key", int'(bif.key), 'h5A3C21);
    chk("t2_kv", int'(bif.key_valid), 1);
    chk("t2_ab0", ab_cnt[0], 1);
    chk("t2_ab1", ab_cnt[1], 0);
    chk("t2_ndisp", lg_core.size(), 2);

    // restart from DONE; both cores valid in same cycle
    lat[0] = 6;
    lat[1] = 5;
    find_en[0] = 1'b1;
    find_key[0] = 24'h123456;
    find_en[1] = 1'b1;
    find_key[1] = 24'h654321;
    clear_logs();
    start_run("t3");
    chk("t3_key_clr", int'(bif.key), 0);
    wait_done("t3");
    chk("t3_c0", qget(lg_core, 0), 0);
    chk("t3_lo0", qget(lg_lo, 0), 0);
    chk("t3_key", int'(bif.key), 'h123456);
    chk("t3_kv", int'(bif.key_valid), 1);
    chk("t3_abort", ab_cnt[0] + ab_cnt[1], 0);

    // async reset mid-run, then restart at chunk 0
    lat[0] = 20;
    lat[1] = 20;
    find_en[0] = 1'b0;
    find_en[1] = 1'b0;
    clear_logs();
    start_run("t4");
    @(negedge clk);
    @(negedge clk);
    chk("t4_pre_en", int'(bif.core_en), 2);
    chk("t4_pre_skey", int'(bif.core_start_key[KW +: KW]), 'h400000);
    #1;
    reset = 1'b0;
    #1;
    chk("t4_rst_en", int'(bif.core_en), 0);
    chk("t4_rst_rdy", int'(bif.rdy), 1);
    chk("t4_rst_kv", int'(bif.key_valid), 0);
    chk("t4_rst_skey", int'(bif.core_start_key), 0);
    @(negedge clk);
    reset = 1'b1;
    clear_logs();
    start_run("t5");
    repeat (3) @(negedge clk);
    chk("t5_c0", qget(lg_core, 0), 0);
    chk("t5_lo0", qget(lg_lo, 0), 0);
    chk("t5_c1", qget(lg_core, 1), 1);
    chk("t5_lo1", qget(lg_lo, 1), 'h400000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
